// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction-fetch front end.
//   RESET_PC_DEFAULT - default first fetch address after reset
//   fetch_state_e    - fetch FSM states (request / wait / drop stale response)
//   fetch_entry_t    - one fetched instruction with its PC and prediction
//   align4()         - clears the two low address bits
package ifu_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } fetch_state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
        logic [63:0] pred_target;
    } fetch_entry_t;

    function automatic logic [63:0] align4(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous circular FIFO with flush.
//   clock, reset - rising-edge clock, synchronous active-high reset
//   flush        - empties the queue; a same-cycle push or pop is ignored
//   push, push_data - write one entry at the tail (caller guarantees space)
//   pop          - remove the head entry (ignored when empty)
//   head         - current head entry
//   count        - number of valid entries (0..DEPTH)
module fetch_queue
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PW-1:0]      head_q, head_d;
    logic [PW-1:0]      tail_q, tail_d;
    logic [PW:0]        count_q, count_d;
    logic               do_push;
    logic               do_pop;

    always_comb begin
        do_push = push && !flush;
        do_pop  = pop && !flush && (count_q != '0);
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) begin
                mem_d[tail_q] = push_data;
                tail_d        = tail_q + 1'b1;
            end
            if (do_pop) begin
                head_d = head_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head  = mem_q[head_q];
    assign count = count_q;

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch front end.
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   io_pc                 - current fetch PC (to branch predictor)
//   io_pre_valid/next_pc  - predictor taken hit and target
//   io_redirect_valid/pc  - execute mispredict redirect (highest priority)
//   io_imem_req_*         - one-at-a-time fetch request handshake
//   io_imem_resp_*        - fetch response, at least one cycle after accept
//   io_out_*              - fetched instruction + prediction to decode
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned FQ_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [63:0] io_pc,
    input  logic        io_pre_valid,
    input  logic [63:0] io_pre_next_pc,
    input  logic        io_redirect_valid,
    input  logic [63:0] io_redirect_pc,
    output logic        io_imem_req_valid,
    input  logic        io_imem_req_ready,
    output logic [63:0] io_imem_req_addr,
    input  logic        io_imem_resp_valid,
    input  logic [31:0] io_imem_resp_data,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic [63:0] io_out_pc,
    output logic [31:0] io_out_inst,
    output logic        io_out_pred_taken,
    output logic [63:0] io_out_pred_target
);

    localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

    fetch_state_e  state_q, state_d;
    logic [63:0]   pc_q, pc_d;
    logic [63:0]   infl_pc_q, infl_pc_d;
    logic          infl_taken_q, infl_taken_d;
    logic [63:0]   infl_target_q, infl_target_d;

    logic          req_valid;
    logic          fire;
    logic          push;
    logic          pop;
    fetch_entry_t  push_data;
    fetch_entry_t  head;
    logic [CW-1:0] count;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        infl_pc_d     = infl_pc_q;
        infl_taken_d  = infl_taken_q;
        infl_target_d = infl_target_q;

        // Issuing only while count < depth reserves the slot for the response.
        req_valid = !reset && (state_q == S_REQ) && (count < DEPTH_C) && !io_redirect_valid;
        fire      = req_valid && io_imem_req_ready;
        push      = (state_q == S_WAIT) && io_imem_resp_valid && !io_redirect_valid;

        push_data = '{pc:          infl_pc_q,
                      inst:        io_imem_resp_data,
                      pred_taken:  infl_taken_q,
                      pred_target: infl_target_q};

        if (io_redirect_valid) begin
            pc_d = align4(io_redirect_pc);
            if (state_q == S_WAIT) begin
                state_d = io_imem_resp_valid ? S_REQ : S_DROP;
            end
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (fire) begin
                        state_d       = S_WAIT;
                        infl_pc_d     = pc_q;
                        infl_taken_d  = io_pre_valid;
                        infl_target_d = align4(io_pre_next_pc);
                        pc_d          = io_pre_valid ? align4(io_pre_next_pc) : pc_q + 64'd4;
                    end
                end
                S_WAIT: begin
                    if (io_imem_resp_valid) state_d = S_REQ;
                end
                S_DROP: begin
                    if (io_imem_resp_valid) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            infl_pc_q     <= '0;
            infl_taken_q  <= 1'b0;
            infl_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            infl_pc_q     <= infl_pc_d;
            infl_taken_q  <= infl_taken_d;
            infl_target_q <= infl_target_d;
        end
    end

    assign pop = io_out_valid && io_out_ready;

    fetch_queue #(
        .DEPTH   (FQ_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fq (
        .clock     (clock),
        .reset     (reset),
        .flush     (io_redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign io_pc              = pc_q;
    assign io_imem_req_addr   = pc_q;
    assign io_imem_req_valid  = req_valid;
    assign io_out_valid       = (count != '0);
    assign io_out_pc          = head.pc;
    assign io_out_inst        = head.inst;
    assign io_out_pred_taken  = head.pred_taken;
    assign io_out_pred_target = head.pred_target;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] io_pc;
    logic        io_pre_valid;
    logic [63:0] io_pre_next_pc;
    logic        io_redirect_valid;
    logic [63:0] io_redirect_pc;
    logic        io_imem_req_valid;
    logic        io_imem_req_ready;
    logic [63:0] io_imem_req_addr;
    logic        io_imem_resp_valid;
    logic [31:0] io_imem_resp_data;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [63:0] io_out_pc;
    logic [31:0] io_out_inst;
    logic        io_out_pred_taken;
    logic [63:0] io_out_pred_target;

    always #5 clock = ~clock;

    ifu_fetch #(.RESET_PC(RST_PC), .FQ_DEPTH(DEPTH)) dut (
        .clock              (clock),
        .reset              (reset),
        .io_pc              (io_pc),
        .io_pre_valid       (io_pre_valid),
        .io_pre_next_pc     (io_pre_next_pc),
        .io_redirect_valid  (io_redirect_valid),
        .io_redirect_pc     (io_redirect_pc),
        .io_imem_req_valid  (io_imem_req_valid),
        .io_imem_req_ready  (io_imem_req_ready),
        .io_imem_req_addr   (io_imem_req_addr),
        .io_imem_resp_valid (io_imem_resp_valid),
        .io_imem_resp_data  (io_imem_resp_data),
        .io_out_valid       (io_out_valid),
        .io_out_ready       (io_out_ready),
        .io_out_pc          (io_out_pc),
        .io_out_inst        (io_out_inst),
        .io_out_pred_taken  (io_out_pred_taken),
        .io_out_pred_target (io_out_pred_target)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        taken;
        logic [63:0] target;
    } m_entry_t;

    logic [63:0] m_pc;
    bit          m_out;      // a request is outstanding
    bit          m_stale;    // the outstanding response must be discarded
    m_entry_t    m_inf;
    m_entry_t    m_q[$];

    function automatic logic [63:0] al(input logic [63:0] a);
        return a & ~64'h3;
    endfunction

    task automatic model_reset();
        m_pc = RST_PC;
        m_out = 0;
        m_stale = 0;
        m_q.delete();
    endtask

    function automatic bit m_req_valid();
        return !m_out && (m_q.size() < DEPTH) && !io_redirect_valid;
    endfunction

    task automatic model_check();
        chk("io_pc", io_pc, m_pc);
        chk("req_addr", io_imem_req_addr, m_pc);
        chk("req_valid", io_imem_req_valid, m_req_valid());
        chk("out_valid", io_out_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("out_pc", io_out_pc, m_q[0].pc);
            chk("out_inst", io_out_inst, m_q[0].inst);
            chk("out_taken", io_out_pred_taken, m_q[0].taken);
            chk("out_target", io_out_pred_target, m_q[0].target);
        end
    endtask

    task automatic model_step();
        bit fire, pop;
        m_entry_t e;
        fire = m_req_valid() && io_imem_req_ready;
        pop  = (m_q.size() != 0) && io_out_ready;
        if (io_redirect_valid) begin
            m_q.delete();
            m_pc = al(io_redirect_pc);
            if (m_out && !m_stale) begin
                if (io_imem_resp_valid) m_out = 0;
                else m_stale = 1;
            end
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_out && io_imem_resp_valid) begin
                if (!m_stale) begin
                    e = m_inf;
                    e.inst = io_imem_resp_data;
                    m_q.push_back(e);
                end
                m_out = 0;
                m_stale = 0;
            end
            if (fire) begin
                m_out = 1;
                m_inf.pc = m_pc;
                m_inf.inst = '0;
                m_inf.taken = io_pre_valid;
                m_inf.target = al(io_pre_next_pc);
                m_pc = io_pre_valid ? al(io_pre_next_pc) : m_pc + 64'd4;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input logic rr, input logic rv, input logic [31:0] rd,
                          input logic orr, input logic pv, input logic [63:0] ppc,
                          input logic rdv, input logic [63:0] rpc);
        io_imem_req_ready  = rr;
        io_imem_resp_valid = rv;
        io_imem_resp_data  = rd;
        io_out_ready       = orr;
        io_pre_valid       = pv;
        io_pre_next_pc     = ppc;
        io_redirect_valid  = rdv;
        io_redirect_pc     = rpc;
        #1;
    endtask

    task automatic end_cyc();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic cyc(input logic rr, input logic rv, input logic [31:0] rd,
                       input logic orr, input logic pv, input logic [63:0] ppc,
                       input logic rdv, input logic [63:0] rpc);
        set_in(rr, rv, rd, orr, pv, ppc, rdv, rpc);
        model_check();
        end_cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(1, 0, 0, 1, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        chk("rst_pc", io_pc, RST_PC);
        chk("rst_req_valid", io_imem_req_valid, 0);
        chk("rst_out_valid", io_out_valid, 0);
        chk("rst_out_pc", io_out_pc, 0);
        chk("rst_out_inst", io_out_inst, 0);
        chk("rst_out_taken", io_out_pred_taken, 0);
        chk("rst_out_target", io_out_pred_target, 0);
        model_reset();
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rr, rv;
        logic [31:0] rd;
        logic        orr, pv;
        logic [63:0] ppc;
        logic [63:0] e_pc;
        logic        e_rv, e_ov;
        logic [63:0] e_opc;
        logic [31:0] e_inst;
        logic        e_pt;
        logic [63:0] e_ptgt;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1, 0, 32'h0,        1, 0, 64'h0,         64'h8000_0000, 1, 0, 64'h0,         32'h0,        0, 64'h0};
        vecs[1] = '{1, 1, 32'h1111_1111, 1, 0, 64'h0,         64'h8000_0004, 0, 0, 64'h0,         32'h0,        0, 64'h0};
        vecs[2] = '{1, 0, 32'h0,        1, 1, 64'h8000_0100, 64'h8000_0004, 1, 1, 64'h8000_0000, 32'h1111_1111, 0, 64'h0};
        vecs[3] = '{1, 1, 32'h2222_2222, 1, 0, 64'h0,         64'h8000_0100, 0, 0, 64'h0,         32'h0,        0, 64'h0};
        vecs[4] = '{1, 0, 32'h0,        1, 0, 64'h0,         64'h8000_0100, 1, 1, 64'h8000_0004, 32'h2222_2222, 1, 64'h8000_0100};
        vecs[5] = '{1, 1, 32'h3333_3333, 1, 0, 64'h0,         64'h8000_0104, 0, 0, 64'h0,         32'h0,        0, 64'h0};
        vecs[6] = '{0, 0, 32'h0,        1, 0, 64'h0,         64'h8000_0104, 1, 1, 64'h8000_0100, 32'h3333_3333, 0, 64'h0};
        vecs[7] = '{1, 0, 32'h0,        1, 0, 64'h0,         64'h8000_0104, 1, 0, 64'h0,         32'h0,        0, 64'h0};

        reset = 1'b1;
        model_reset();

        // Reset, then a predicted-taken sequence checked against fixed vectors.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_in(vecs[i].rr, vecs[i].rv, vecs[i].rd, vecs[i].orr, vecs[i].pv, vecs[i].ppc, 0, 0);
            chk($sformatf("v%0d_pc", i), io_pc, vecs[i].e_pc);
            chk($sformatf("v%0d_req_valid", i), io_imem_req_valid, vecs[i].e_rv);
            chk($sformatf("v%0d_out_valid", i), io_out_valid, vecs[i].e_ov);
            if (vecs[i].e_ov) begin
                chk($sformatf("v%0d_out_pc", i), io_out_pc, vecs[i].e_opc);
                chk($sformatf("v%0d_out_inst", i), io_out_inst, vecs[i].e_inst);
                chk($sformatf("v%0d_out_taken", i), io_out_pred_taken, vecs[i].e_pt);
                chk($sformatf("v%0d_out_target", i), io_out_pred_target, vecs[i].e_ptgt);
            end
            @(posedge clock);
            #1;
        end

        // Backpressure: decode stalled, queue fills to two, then drains in order.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, m_out, $urandom, 0, 0, 0, 0, 0);
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        model_check();
        chk("full_req_valid", io_imem_req_valid, 0);
        chk("full_head_pc", io_out_pc, 64'h8000_0000);
        chk("full_pc", io_pc, 64'h8000_0008);
        end_cyc();
        for (int i = 0; i < 8; i++) cyc(1, m_out, $urandom, 1, 0, 0, 0, 0);

        // Redirect while the request for 0x80000008 is outstanding.
        do_reset();
        cyc(1, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 1, 32'hA000_0000, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 1, 32'hA000_0004, 1, 0, 0, 0, 0);
        set_in(1, 0, 0, 1, 0, 0, 0, 0);
        model_check();
        chk("rdo_req_addr", io_imem_req_addr, 64'h8000_0008);
        end_cyc();
        set_in(1, 0, 0, 1, 0, 0, 1, 64'h8000_0203);
        model_check();
        end_cyc();
        set_in(1, 1, 32'hDEAD_BEEF, 1, 0, 0, 0, 0);
        model_check();
        chk("rdo_drop_out_valid", io_out_valid, 0);
        chk("rdo_drop_req_valid", io_imem_req_valid, 0);
        chk("rdo_drop_pc", io_pc, 64'h8000_0200);
        end_cyc();
        set_in(1, 0, 0, 1, 0, 0, 0, 0);
        model_check();
        chk("rdo_new_req_valid", io_imem_req_valid, 1);
        chk("rdo_new_req_addr", io_imem_req_addr, 64'h8000_0200);
        end_cyc();
        cyc(1, 1, 32'hB000_0200, 0, 0, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        model_check();
        chk("rdo_first_out_pc", io_out_pc, 64'h8000_0200);
        chk("rdo_first_out_inst", io_out_inst, 32'hB000_0200);
        end_cyc();

        // Redirect coincident with response and pop.
        do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 32'hC000_0000, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        set_in(1, 1, 32'hC000_0004, 1, 0, 0, 1, 64'h8000_0401);
        model_check();
        chk("rc_out_valid_before", io_out_valid, 1);
        end_cyc();
        set_in(1, 0, 0, 1, 0, 0, 0, 0);
        model_check();
        chk("rc_out_valid", io_out_valid, 0);
        chk("rc_req_valid", io_imem_req_valid, 1);
        chk("rc_req_addr", io_imem_req_addr, 64'h8000_0400);
        end_cyc();
        cyc(1, 1, 32'hC000_0400, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 0);

        // Reset mid-flight, then a late response.
        cyc(1, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 1, 32'h1234_5678, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 0);
        do_reset();
        set_in(1, 1, 32'hFEED_FACE, 1, 0, 0, 0, 0);
        model_check();
        chk("rm_req_addr", io_imem_req_addr, RST_PC);
        chk("rm_req_valid", io_imem_req_valid, 1);
        end_cyc();
        set_in(1, 0, 0, 1, 0, 0, 0, 0);
        model_check();
        chk("rm_out_valid", io_out_valid, 0);
        end_cyc();

        // Randomised traffic against the reference model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic rv;
            rv = m_out ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
            cyc($urandom_range(0, 3) != 0, rv, $urandom, $urandom_range(0, 2) != 0,
                $urandom_range(0, 3) == 0, {$urandom, $urandom} & ~64'h3,
                $urandom_range(0, 15) == 0, {$urandom, $urandom});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
